// File: rtl/branch_control_unit.sv
// branch_control_unit
//   Program counter, registered condition flags and a small hardware return
//   stack for the CPU decoder. Conditional jumps, calls and returns resolve on
//   the execute strobe. The PC advances on the fetch (increment) strobe. The
//   first fetch increment after a taken control transfer is swallowed, so the
//   fetch that follows starts at the new target.
//
// Ports
//   clock        rising-edge system clock
//   clear        asynchronous, active-high reset
//   increment    fetch strobe: pc <= pc+1 (unless a transfer or pending skip)
//   execute      qualifies branch/call/ret in the same cycle
//   branch/call/ret  control op request, priority ret > call > branch
//   cond         condition select, evaluated on the registered flags
//   target       jump/call destination
//   flags_we     load {neg_in, carry_in, zero_in} on this edge
//   pc           current program counter (registered only)
//   taken        one-cycle pulse: a transfer was taken on the last edge
//   flags        {neg, carry, zero}
//   stack_level  return-stack occupancy
//   stack_ovf/stack_unf  sticky error flags, cleared only by clear
//
// Strobe semantics: increment and execute are single-cycle level strobes that
// are sampled on every rising edge. There is no back-pressure, so every strobe
// seen on an edge is acted on during that edge.
module branch_control_unit #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              increment,
  input  logic              execute,
  input  logic              branch,
  input  logic              call,
  input  logic              ret,
  input  logic [2:0]        cond,
  input  logic [ADDR_W-1:0] target,
  input  logic              flags_we,
  input  logic              zero_in,
  input  logic              carry_in,
  input  logic              neg_in,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic [2:0]        flags,
  output logic [LVL_W-1:0]  stack_level,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic              pending_skip;
  logic              cond_ok;
  logic              do_ret, do_call, do_branch;
  logic              ret_take, ret_unf, call_take, call_ovf, branch_take;
  logic              xfer;
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;

  // The condition is evaluated on the registered flags, so a flags_we in the
  // same cycle does not affect it.
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      3'b000: cond_ok = 1'b1;
      3'b001: cond_ok = flags[0];
      3'b010: cond_ok = ~flags[0];
      3'b011: cond_ok = flags[1];
      3'b100: cond_ok = ~flags[1];
      3'b101: cond_ok = flags[2];
      3'b110: cond_ok = ~flags[2];
      default: cond_ok = 1'b0;
    endcase
  end

  // A higher-priority request masks the lower ones even when its own
  // condition is false.
  assign do_ret    = execute & ret;
  assign do_call   = execute & call & ~ret;
  assign do_branch = execute & branch & ~ret & ~call;

  assign ret_take    = do_ret & cond_ok & (stack_level != '0);
  assign ret_unf     = do_ret & cond_ok & (stack_level == '0);
  assign call_take   = do_call & cond_ok & (stack_level < LVL_W'(STACK_DEPTH));
  assign call_ovf    = do_call & cond_ok & (stack_level == LVL_W'(STACK_DEPTH));
  assign branch_take = do_branch & cond_ok;
  assign xfer        = ret_take | call_take | branch_take;

  assign push_idx = IDX_W'(stack_level);
  assign pop_idx  = IDX_W'(stack_level - LVL_W'(1));
  assign pc_inc   = pc + ADDR_W'(1);

  // A taken transfer wins over the fetch increment. A pending skip swallows
  // exactly one increment strobe.
  always_comb begin
    pc_next = pc;
    if (ret_take) begin
      pc_next = stack_mem[pop_idx];
    end else if (call_take || branch_take) begin
      pc_next = target;
    end else if (increment && !pending_skip) begin
      pc_next = pc_inc;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pc           <= '0;
      flags        <= '0;
      taken        <= 1'b0;
      stack_level  <= '0;
      stack_ovf    <= 1'b0;
      stack_unf    <= 1'b0;
      pending_skip <= 1'b0;
    end else begin
      pc    <= pc_next;
      taken <= xfer;
      if (flags_we) begin
        flags <= {neg_in, carry_in, zero_in};
      end
      if (ret_take) begin
        stack_level <= stack_level - LVL_W'(1);
      end else if (call_take) begin
        stack_level <= stack_level + LVL_W'(1);
      end
      if (xfer) begin
        pending_skip <= 1'b1;
      end else if (increment) begin
        pending_skip <= 1'b0;
      end
      if (ret_unf) begin
        stack_unf <= 1'b1;
      end
      if (call_ovf) begin
        stack_ovf <= 1'b1;
      end
    end
  end

  // Stack contents carry no reset. Only occupancy matters after clear.
  always_ff @(posedge clock) begin
    if (call_take) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_branch_control_unit.sv
module tb_branch_control_unit;

  localparam int AW = 8;
  localparam int W  = AW + 1 + 3 + 3 + 1 + 1;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          increment = 1'b0, execute = 1'b0;
  logic          branch = 1'b0, call = 1'b0, ret = 1'b0;
  logic [2:0]    cond = 3'b000;
  logic [AW-1:0] target = '0;
  logic          flags_we = 1'b0, zero_in = 1'b0, carry_in = 1'b0, neg_in = 1'b0;
  logic [AW-1:0] pc;
  logic          taken;
  logic [2:0]    flags;
  logic [2:0]    stack_level;
  logic          stack_ovf, stack_unf;

  logic [W-1:0]  exp_q [$];
  logic [2:0]    exp_flags = 3'b000;
  int            total = 0;
  int            bad = 0;

  branch_control_unit #(.ADDR_W(AW), .STACK_DEPTH(4)) dut (
    .clock(clock), .clear(clear), .increment(increment), .execute(execute),
    .branch(branch), .call(call), .ret(ret), .cond(cond), .target(target),
    .flags_we(flags_we), .zero_in(zero_in), .carry_in(carry_in), .neg_in(neg_in),
    .pc(pc), .taken(taken), .flags(flags), .stack_level(stack_level),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  // clock
  always #5 clock = ~clock;

  // scoreboard monitor: compares DUT state on the falling edge after each push
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {pc, taken, flags, stack_level, stack_ovf, stack_unf};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL state#%0d: got pc=%02h tk=%b fl=%03b lvl=%0d ovf=%b unf=%b want pc=%02h tk=%b fl=%03b lvl=%0d ovf=%b unf=%b",
                 total, a[16:9], a[8], a[7:5], a[4:2], a[1], a[0],
                 e[16:9], e[8], e[7:5], e[4:2], e[1], e[0]);
      end
    end
  end

  task automatic expect_st(input logic [AW-1:0] p, input logic tk, input logic [2:0] lvl,
                           input logic ovf, input logic unf);
    exp_q.push_back({p, tk, exp_flags, lvl, ovf, unf});
  endtask

  // one clock of stimulus; strobes are dropped right after the edge
  task automatic cyc(input logic inc, input logic ex, input logic br, input logic ca,
                     input logic rt, input logic [2:0] cnd, input logic [AW-1:0] tgt,
                     input logic fwe, input logic [2:0] nf);
    @(negedge clock);
    increment = inc; execute = ex; branch = br; call = ca; ret = rt;
    cond = cnd; target = tgt; flags_we = fwe;
    {neg_in, carry_in, zero_in} = nf;
    @(posedge clock);
    #1;
    increment = 1'b0; execute = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
    flags_we = 1'b0;
  endtask

  task automatic inc1();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, '0, 1'b0, 3'b000);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, '0, 1'b0, 3'b000);
  endtask

  task automatic exe(input logic br, input logic ca, input logic rt,
                     input logic [2:0] cnd, input logic [AW-1:0] tgt);
    cyc(1'b0, 1'b1, br, ca, rt, cnd, tgt, 1'b0, 3'b000);
  endtask

  task automatic setf(input logic [2:0] nf);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, '0, 1'b1, nf);
    exp_flags = nf;
  endtask

  initial begin
    // reset state
    @(posedge clock); @(posedge clock); #1;
    expect_st(8'h00, 0, 0, 0, 0);
    @(negedge clock); clear = 1'b0;

    // increments and wrap
    inc1(); expect_st(8'h01, 0, 0, 0, 0);
    inc1(); expect_st(8'h02, 0, 0, 0, 0);
    inc1(); expect_st(8'h03, 0, 0, 0, 0);
    exe(1, 0, 0, 3'b000, 8'hFE); expect_st(8'hFE, 1, 0, 0, 0);
    inc1(); expect_st(8'hFE, 0, 0, 0, 0);
    inc1(); expect_st(8'hFF, 0, 0, 0, 0);
    inc1(); expect_st(8'h00, 0, 0, 0, 0);

    // flags then conditional branch on Z
    setf(3'b001); expect_st(8'h00, 0, 0, 0, 0);
    exe(1, 0, 0, 3'b001, 8'h40); expect_st(8'h40, 1, 0, 0, 0);
    idle(); expect_st(8'h40, 0, 0, 0, 0);
    inc1(); expect_st(8'h40, 0, 0, 0, 0);
    inc1(); expect_st(8'h41, 0, 0, 0, 0);

    // same-cycle flag write is not seen by the condition
    setf(3'b000); expect_st(8'h41, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 8'h55, 1'b1, 3'b001);
    exp_flags = 3'b001;
    expect_st(8'h41, 0, 0, 0, 0);
    inc1(); expect_st(8'h42, 0, 0, 0, 0);   // false branch sets no skip
    exe(1, 0, 0, 3'b010, 8'h77); expect_st(8'h42, 0, 0, 0, 0);
    exe(1, 0, 0, 3'b111, 8'h77); expect_st(8'h42, 0, 0, 0, 0);
    setf(3'b110); expect_st(8'h42, 0, 0, 0, 0);
    exe(1, 0, 0, 3'b100, 8'h77); expect_st(8'h42, 0, 0, 0, 0);
    exe(1, 0, 0, 3'b101, 8'h10); expect_st(8'h10, 1, 0, 0, 0);
    inc1(); expect_st(8'h10, 0, 0, 0, 0);

    // call and return
    exe(0, 1, 0, 3'b000, 8'h80); expect_st(8'h80, 1, 1, 0, 0);
    inc1(); expect_st(8'h80, 0, 1, 0, 0);
    inc1(); expect_st(8'h81, 0, 1, 0, 0);
    exe(0, 0, 1, 3'b000, 8'h00); expect_st(8'h11, 1, 0, 0, 0);
    inc1(); expect_st(8'h11, 0, 0, 0, 0);

    // nested calls to overflow, then returns to underflow
    exe(0, 1, 0, 3'b000, 8'h20); expect_st(8'h20, 1, 1, 0, 0);
    exe(0, 1, 0, 3'b000, 8'h30); expect_st(8'h30, 1, 2, 0, 0);
    exe(0, 1, 0, 3'b000, 8'h40); expect_st(8'h40, 1, 3, 0, 0);
    exe(0, 1, 0, 3'b000, 8'h50); expect_st(8'h50, 1, 4, 0, 0);
    exe(0, 1, 0, 3'b000, 8'h60); expect_st(8'h50, 0, 4, 1, 0);
    exe(0, 0, 1, 3'b000, 8'h00); expect_st(8'h41, 1, 3, 1, 0);
    exe(0, 0, 1, 3'b000, 8'h00); expect_st(8'h31, 1, 2, 1, 0);
    exe(0, 0, 1, 3'b000, 8'h00); expect_st(8'h21, 1, 1, 1, 0);
    exe(0, 0, 1, 3'b000, 8'h00); expect_st(8'h12, 1, 0, 1, 0);
    exe(0, 0, 1, 3'b000, 8'h00); expect_st(8'h12, 0, 0, 1, 1);

    // priority ret > call > branch
    inc1(); expect_st(8'h12, 0, 0, 1, 1);
    exe(0, 1, 0, 3'b000, 8'h70); expect_st(8'h70, 1, 1, 1, 1);
    exe(1, 1, 1, 3'b000, 8'h99); expect_st(8'h13, 1, 0, 1, 1);

    // transfer wins over a same-cycle increment
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 8'h22, 1'b0, 3'b000);
    expect_st(8'h22, 1, 0, 1, 1);

    // asynchronous clear mid-sequence, with a skip still pending
    @(posedge clock); #2;
    clear = 1'b1;
    #1;
    exp_flags = 3'b000;
    expect_st(8'h00, 0, 0, 0, 0);
    @(posedge clock); #1;
    expect_st(8'h00, 0, 0, 0, 0);
    @(negedge clock); clear = 1'b0;
    inc1(); expect_st(8'h01, 0, 0, 0, 0);

    @(negedge clock); @(negedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_control_unit.md
Name: branch_control_unit

Overview:
- Parametrised program-counter and branch-resolution block for the CPU decoder.
- Holds the PC, registered condition flags and a small hardware return stack.
- Resolves conditional jumps, calls and returns in the execute phase, and advances the PC in the fetch phase.
- Suppresses the fetch increment that immediately follows a taken control transfer.

Parameters:
- ADDR_W, 8, width of PC, target and return addresses.
- STACK_DEPTH, 4, return-stack entries (>=1); occupancy counter is clog2(STACK_DEPTH+1) bits.

Ports:
- clock  in  1  single system clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- increment  in  1  fetch-phase strobe: PC <= PC+1
- execute  in  1  execute-phase strobe: qualifies branch/call/ret
- branch  in  1  current instruction is a jump
- call  in  1  current instruction is a call
- ret  in  1  current instruction is a return
- cond  in  3  condition select (see Behaviour)
- target  in  ADDR_W  jump/call destination
- flags_we  in  1  load flag registers this cycle
- zero_in, carry_in, neg_in  in  1 each  new flag values
- pc  out  ADDR_W  current program counter
- taken  out  1  registered: a control transfer was taken last cycle
- flags  out  3  {neg, carry, zero} registered flags
- stack_level  out  clog2(STACK_DEPTH+1)  current return-stack occupancy
- stack_ovf, stack_unf  out  1 each  sticky error flags

Behaviour:
- Reset (clear=1, asynchronous): pc=0, flags=0, taken=0, stack_level=0, stack_ovf=0, stack_unf=0, pending-skip=0. Stack contents are don't-care.
- cond decode, evaluated on registered flags (the value before any same-cycle flags_we update):
  - 000 always
  - 001 Z, 010 !Z
  - 011 C, 100 !C
  - 101 N, 110 !N
  - 111 never
- flags_we=1: flags load on the clock edge, independent of all other strobes.
- Control op selection when execute=1:
  - Priority ret > call > branch; lower-priority requests are ignored.
  - ok = decoded condition true.
- ret & ok:
  - level>0: pc <= top entry, level-1, taken<=1.
  - level==0: pc unchanged, stack_unf<=1, taken<=0.
- call & ok:
  - level<STACK_DEPTH: push pc+1 (mod 2^ADDR_W), pc <= target, level+1, taken<=1.
  - level full: no push, pc unchanged, stack_ovf<=1, taken<=0.
- branch & ok: pc <= target, taken<=1.
- Condition false, or no op requested: taken<=0, pc follows the increment rule below.
- taken pulses for exactly one cycle per transfer.
- increment rule:
  - Applies only when no control transfer is taken in the same cycle (a taken transfer wins).
  - pending-skip=1: pc holds and pending-skip clears.
  - Otherwise pc <= pc+1 and wraps from 2^ADDR_W-1 to 0.
- pending-skip is set by every taken transfer; it is cleared by the next increment strobe or by clear.
- Condition-false executes do not set pending-skip.
- Latency: pc and taken update on the edge that samples execute; no combinational path from inputs to pc.
- Sticky errors are cleared only by clear. Error conditions never corrupt pc or the stack.
- clear asserted mid-operation aborts immediately; the first edge after deassertion behaves as a fresh start.

Test Plan:
- Reset, then 3 increment pulses -> pc=3; with ADDR_W=8 and pc=255, 1 increment -> pc=0.
- flags_we zero_in=1 at cycle n; execute branch cond=001 target=0x40 at cycle n+1 -> pc=0x40, taken=1 for one cycle. The next increment leaves pc=0x40; the following increment gives pc=0x41.
- Same-cycle flags_we zero_in=1 with execute branch cond=001 from zero=0 -> not taken; pc unchanged; taken=0.
- pc=0x10, call target=0x80 cond=000 -> pc=0x80, stack_level=1. Later ret cond=000 -> pc=0x11, stack_level=0.
- STACK_DEPTH=4: 5 nested calls -> 5th leaves pc unchanged, stack_ovf=1, stack_level=4. Then 5 rets -> 4 pop correctly, 5th sets stack_unf=1.
- Simultaneous ret+call+branch with level=1 -> ret performed only. Asserting clear mid-sequence -> all outputs 0 asynchronously, before the next edge.
